// File: rtl/dec_input_seq_pkg.sv
// Shared controller constants for the serial unlock sequencer: FSM encoding,
// index width and a busy-state helper.
package dec_input_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MATCH    = 2'd1,
    ST_MODE_CAP = 2'd2,
    ST_ACTIVE   = 2'd3
  } ctl_state_e;

  // Wide enough for indices up to 16 (max of KEY_LEN and MODE_BITS).
  localparam int IDX_W = 5;

  function automatic logic is_busy(input ctl_state_e s);
    return (s == ST_MATCH) || (s == ST_MODE_CAP);
  endfunction

endpackage

// File: rtl/dec_input_seq_timeout.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle on which the count reaches TIMEOUT. TIMEOUT=0 never expires.
module seq_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  // Combinational so the FSM leaves on the same edge the count reaches TIMEOUT.
  assign expired = (TIMEOUT > 0) && en && !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expired) cnt_d = '0;
    else if (en)        cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dec_input_seq.sv
// Serial unlock sequencer: matches KEY_PATTERN MSB-first, captures MODE_BITS
// mode bits, then stays ACTIVE until clear/reset. All outputs registered.
module dec_input_seq
  import dec_input_seq_pkg::*;
#(
  parameter int                 KEY_LEN     = 4,
  parameter logic [KEY_LEN-1:0] KEY_PATTERN = 4'b1010,
  parameter int                 MODE_BITS   = 1,
  parameter int                 TIMEOUT     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_key,
  input  logic                 valid_cmd,
  input  logic                 clear,
  output logic                 active,
  output logic [MODE_BITS-1:0] mode,
  output logic                 busy,
  output logic                 err,
  output logic                 done
);

  ctl_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [MODE_BITS-1:0] mreg_q, mreg_d;
  logic                 active_q, active_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic [MODE_BITS-1:0] mode_q, mode_d;

  logic                 accept;
  logic                 abort;
  logic                 expired;
  logic [KEY_LEN-1:0]   pat_sh;

  assign accept = valid_cmd && !clear;

  seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (!is_busy(state_q) || valid_cmd || clear),
    .en      (is_busy(state_q)),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      mreg_q   <= '0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mreg_q   <= mreg_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mreg_d  = mreg_q;
    abort   = 1'b0;
    // Expected key sits at the MSB after shifting out the bits already matched.
    pat_sh  = KEY_PATTERN << idx_q;
    if (clear) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      mreg_d  = '0;
      abort   = is_busy(state_q);
    end else if (expired) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      mreg_d  = '0;
      abort   = 1'b1;
    end else if (accept) begin
      case (state_q)
        ST_IDLE, ST_MATCH: begin
          if (input_key == pat_sh[KEY_LEN-1]) begin
            if (idx_q == IDX_W'(KEY_LEN - 1)) begin
              state_d = ST_MODE_CAP;
              idx_d   = '0;
              mreg_d  = '0;
            end else begin
              state_d = ST_MATCH;
              idx_d   = idx_q + IDX_W'(1);
            end
          end else if (state_q == ST_MATCH) begin
            abort = 1'b1;
            // A mismatching key may itself be the start of a new attempt.
            if (input_key == KEY_PATTERN[KEY_LEN-1]) begin
              state_d = ST_MATCH;
              idx_d   = IDX_W'(1);
            end else begin
              state_d = ST_IDLE;
              idx_d   = '0;
            end
          end
        end
        ST_MODE_CAP: begin
          mreg_d    = mreg_q << 1;
          mreg_d[0] = input_key;
          if (idx_q == IDX_W'(MODE_BITS - 1)) begin
            state_d = ST_ACTIVE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    active_d = (state_d == ST_ACTIVE);
    busy_d   = is_busy(state_d);
    err_d    = abort;
    done_d   = active_d && (state_q != ST_ACTIVE);
    mode_d   = active_d ? mreg_d : '0;
  end

  assign active = active_q;
  assign busy   = busy_q;
  assign err    = err_q;
  assign done   = done_q;
  assign mode   = mode_q;

endmodule

// File: tb/tb_dec_input_seq.sv
// Bench for dec_input_seq: default instance checked every cycle against a
// progress-count model; a second instance covers a long pattern without timeout.
module tb_dec_input_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key0 = 1'b0, vld0 = 1'b0, clr0 = 1'b0;
  logic key1 = 1'b0, vld1 = 1'b0, clr1 = 1'b0;

  logic       active0, busy0, err0, done0;
  logic [0:0] mode0;
  logic       active1, busy1, err1, done1;
  logic [2:0] mode1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dec_input_seq u_dut0 (
    .clk(clk), .reset(rst_n), .input_key(key0), .valid_cmd(vld0), .clear(clr0),
    .active(active0), .mode(mode0), .busy(busy0), .err(err0), .done(done0)
  );

  dec_input_seq #(
    .KEY_LEN(6), .KEY_PATTERN(6'b110010), .MODE_BITS(3), .TIMEOUT(0)
  ) u_dut1 (
    .clk(clk), .reset(rst_n), .input_key(key1), .valid_cmd(vld1), .clear(clr1),
    .active(active1), .mode(mode1), .busy(busy1), .err(err1), .done(done1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: progress = number of keys consumed toward unlock
  // (KL pattern keys then MB mode keys); unlocked when progress reaches KL+MB.
  localparam int KL = 4, MB = 1, TO = 16, TOT = KL + MB;
  logic [3:0] kp = 4'b1010;
  int m_pos = 0, m_mode = 0, m_idle = 0;
  bit m_err = 0, m_done = 0;

  function automatic logic [4:0] m_outs();
    bit act = (m_pos == TOT);
    bit bsy = (m_pos > 0) && (m_pos < TOT);
    return {act, bsy, m_err, m_done, act ? m_mode[0] : 1'b0};
  endfunction

  task automatic model_reset();
    m_pos = 0; m_mode = 0; m_idle = 0; m_err = 0; m_done = 0;
  endtask

  task automatic model_step(input bit k, input bit v, input bit c);
    bit was_busy = (m_pos > 0) && (m_pos < TOT);
    m_err = 0; m_done = 0;
    if (c) begin
      m_err = was_busy; m_pos = 0; m_mode = 0; m_idle = 0;
    end else if (v && m_pos < TOT) begin
      m_idle = 0;
      if (m_pos < KL) begin
        if (k == kp[KL-1-m_pos]) begin
          m_pos++;
          if (m_pos == KL) m_mode = 0;
        end else if (m_pos > 0) begin
          m_err = 1;
          m_pos = (k == kp[KL-1]) ? 1 : 0;
        end
      end else begin
        m_mode = m_mode * 2 + int'(k);
        m_pos++;
        if (m_pos == TOT) m_done = 1;
      end
    end else if (was_busy) begin
      m_idle++;
      if (m_idle == TO) begin
        m_err = 1; m_pos = 0; m_mode = 0; m_idle = 0;
      end
    end else begin
      m_idle = 0;
    end
  endtask

  task automatic tick(input bit k, input bit v, input bit c);
    @(negedge clk);
    key0 = k; vld0 = v; clr0 = c;
    @(posedge clk);
    model_step(k, v, c);
    #1;
    chk("dut0_outs", {27'd0, active0, busy0, err0, done0, mode0}, {27'd0, m_outs()});
    key0 = 1'b0; vld0 = 1'b0; clr0 = 1'b0;
  endtask

  task automatic tick1(input bit k, input bit v);
    key1 = k; vld1 = v;
    tick(1'b0, 1'b0, 1'b0);
    key1 = 1'b0; vld1 = 1'b0;
  endtask

  task automatic keys0(input logic [7:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) tick(seq[i], 1'b1, 1'b0);
  endtask

  initial begin
    logic [5:0] p1;
    bit err_seen;
    p1 = 6'b110010;

    #2;
    chk("reset_dut0", {28'd0, active0, busy0, err0, done0}, 32'd0);
    chk("reset_mode0", {31'd0, mode0}, 32'd0);
    chk("reset_dut1", {25'd0, active1, busy1, err1, done1, mode1}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Pattern 1010, mode 1 -> unlock, done pulses once
    keys0(8'b10101, 5);
    chk("unlock_done", {31'd0, done0}, 32'd1);
    tick(0, 0, 0);
    chk("unlock_active", {29'd0, active0, mode0, busy0}, {29'd0, 3'b110});
    chk("unlock_done_once", {31'd0, done0}, 32'd0);
    tick(0, 0, 1);

    // 1,0,1,1 aborts but the last key restarts; 0,1,0 completes, mode 0
    keys0(8'b1011, 4);
    chk("restart_err", {30'd0, err0, busy0}, 32'd3);
    keys0(8'b0100, 4);
    chk("restart_active", {30'd0, active0, mode0}, 32'd2);
    tick(0, 0, 1);

    // Timeout: err exactly on the 16th idle cycle
    keys0(8'b10, 2);
    for (int i = 1; i <= 16; i++) tick(0, 0, 0);
    chk("timeout_err", {30'd0, err0, busy0}, 32'd2);
    tick(0, 0, 0);

    // Clear with valid during MODE_CAP: err, no done; ACTIVE ignores keys
    keys0(8'b1010, 4);
    tick(1, 1, 1);
    chk("clear_modecap", {29'd0, err0, done0, active0}, 32'd4);
    keys0(8'b10101, 5);
    for (int i = 0; i < 6; i++) tick(1'(i), 1, 0);
    chk("active_hold", {30'd0, active0, mode0}, 32'd3);
    tick(0, 0, 1);
    chk("clear_active_noerr", {31'd0, err0}, 32'd0);

    // Asynchronous reset mid-pattern: outputs drop before the next edge
    keys0(8'b10, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {28'd0, active0, busy0, err0, done0}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    keys0(8'b10101, 5);
    chk("post_reset_unlock", {30'd0, active0, mode0}, 32'd3);
    tick(0, 0, 1);

    // Long-pattern instance: no timeout across a 100-cycle gap
    for (int i = 5; i >= 3; i--) tick1(p1[i], 1);
    err_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick1(0, 0);
      if (err1 || !busy1) err_seen = 1;
    end
    chk("dut1_no_timeout", {31'd0, err_seen}, 32'd0);
    for (int i = 2; i >= 0; i--) tick1(p1[i], 1);
    tick1(1, 1); tick1(0, 1); tick1(1, 1);
    chk("dut1_unlock", {26'd0, active1, done1, busy1, mode1}, {26'd0, 3'b110, 3'b101});
    tick1(0, 0);
    chk("dut1_hold", {27'd0, active1, done1, mode1}, {27'd0, 2'b10, 3'b101});

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      tick(1'($urandom_range(1)), ($urandom_range(9) < 7), ($urandom_range(99) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
